axi_lite_settings_bridge: RTL and testbench
===========================================

AXI_LITE_SETTINGS_BRIDGE -- requirements
Module: axi_lite_settings_bridge

Interface
REQ-001 Parameter C_DATAWIDTH, default 32: AXI-Lite data width and set_data/get_data width.
REQ-002 Parameter C_ADDRWIDTH, default 32: AXI-Lite address width and set_addr/get_addr width.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 s_axi_awaddr  input  C_ADDRWIDTH  write address.
REQ-006 s_axi_awvalid/s_axi_awready  input/output  1  write-address handshake.
REQ-007 s_axi_wdata  input  C_DATAWIDTH  write data.
REQ-008 s_axi_wstrb  input  C_DATAWIDTH/8  write byte strobes.
REQ-009 s_axi_wvalid/s_axi_wready  input/output  1  write-data handshake.
REQ-010 s_axi_bresp  output  2  write response (00 OKAY, 10 SLVERR).
REQ-011 s_axi_bvalid/s_axi_bready  output/input  1  write-response handshake.
REQ-012 s_axi_araddr  input  C_ADDRWIDTH  read address.
REQ-013 s_axi_arvalid/s_axi_arready  input/output  1  read-address handshake.
REQ-014 s_axi_rdata  output  C_DATAWIDTH  read data.
REQ-015 s_axi_rresp  output  2  read response, always 00.
REQ-016 s_axi_rvalid/s_axi_rready  output/input  1  read-data handshake.
REQ-017 set_data/set_addr/set_stb  output  C_DATAWIDTH/C_ADDRWIDTH/1  settings write port to the register bank.
REQ-018 get_addr/get_stb  output  C_ADDRWIDTH/1  settings read request to the register bank.
REQ-019 get_data  input  C_DATAWIDTH  combinational read data from the register bank, valid in the get_stb cycle.

Function
REQ-020 Write FSM states: W_IDLE, W_STB, W_RESP; read FSM states: R_IDLE, R_STB, R_RESP; both FSMs run independently and concurrently.
REQ-021 In W_IDLE, awready SHALL be high until AW has been captured and wready high until W has been captured; AW and W are accepted in either order or in the same cycle.
REQ-022 When both AW and W are captured, the FSM SHALL move to W_STB; set_stb is high for exactly one cycle in W_STB, with set_addr/set_data holding the captured values.
REQ-023 W_STB SHALL always move to W_RESP; bvalid is high in W_RESP until the bvalid&&bready cycle, then return to W_IDLE.
REQ-024 Write latency: with AW and W in cycle N, set_stb in N+1, bvalid in N+2 at the earliest.
REQ-025 In R_IDLE arready SHALL be high; the arvalid&&arready cycle captures araddr and moves to R_STB.
REQ-026 In R_STB get_stb SHALL be high for exactly one cycle with get_addr = captured address; get_data is registered into rdata at the end of that cycle; the FSM then moves to R_RESP.
REQ-027 In R_RESP rvalid SHALL be high and rdata stable until rvalid&&rready, then return to R_IDLE.
REQ-028 Read latency: AR in cycle N, get_stb in N+1, rvalid in N+2.
REQ-029 set_addr, set_data, get_addr and rdata SHALL hold their last values outside strobe and response cycles; no new transaction is accepted while a response is pending (one outstanding transaction per direction).
REQ-030 Address bits SHALL pass through unmodified; alignment decoding belongs to the register bank.
REQ-031 A set_stb and a get_stb in the same cycle are legal and SHALL NOT delay each other.

Reset
REQ-032 While rst is high, both FSMs SHALL go to IDLE; awready, wready, arready low; bvalid, rvalid, set_stb, get_stb low; bresp, rresp 00; set_addr, set_data, get_addr, rdata zero.
REQ-033 Reset asserted mid-transaction SHALL drop the transaction with no strobe and no response; ready signals rise on the first cycle after rst deasserts.

Configuration
REQ-034 Macro SETTINGS_BRIDGE_STRB_CHECK_EN defined: a write whose wstrb is not all ones SHALL suppress set_stb in W_STB and return bresp=10 (SLVERR).
REQ-035 Macro undefined: wstrb SHALL be ignored; every write pulses set_stb and returns bresp=00.

Verification
REQ-036 AW addr 0x04 and W data 0x0000001F in the same cycle, bready=1 -> set_stb one cycle later with set_addr=0x04, set_data=0x1F; bvalid, bresp=00 one cycle after that.
REQ-037 W data 0xA5 three cycles before AW addr 0x08 -> wready low after W capture, a single set_stb after AW is accepted, set_data=0xA5.
REQ-038 AR addr 0x00, bank drives 0xACE0BA53 during get_stb, rready held low 5 cycles -> rvalid held, rdata=0xACE0BA53 stable, arready low until rready handshake.
REQ-039 Simultaneous write to 0x0C and read of 0x14 -> set_stb and get_stb in the same cycle, both responses complete correctly.
REQ-040 rst pulsed in W_STB cycle -> set_stb low, no bvalid, all outputs reset; the next write completes normally.
REQ-041 With SETTINGS_BRIDGE_STRB_CHECK_EN, wstrb=0x3 -> no set_stb, bresp=10; without it -> set_stb, bresp=00.

Source files
------------

// File: rtl/axi_lite_settings_bridge.sv
// AXI-Lite slave to settings-bus bridge; define SETTINGS_BRIDGE_STRB_CHECK_EN to reject partial-strobe writes with SLVERR.
// Latency: AW+W (or AR) accepted in cycle N -> set_stb/get_stb in N+1 -> bvalid/rvalid in N+2.
// Backpressure: one outstanding transaction per direction; readys stay low until the response is taken.
module axi_lite_settings_bridge #(
  parameter int C_DATAWIDTH = 32,
  parameter int C_ADDRWIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [C_ADDRWIDTH-1:0]     s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [C_DATAWIDTH-1:0]     s_axi_wdata,
  input  logic [C_DATAWIDTH/8-1:0]   s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [C_ADDRWIDTH-1:0]     s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [C_DATAWIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [C_DATAWIDTH-1:0]     set_data,
  output logic [C_ADDRWIDTH-1:0]     set_addr,
  output logic                       set_stb,
  output logic [C_ADDRWIDTH-1:0]     get_addr,
  output logic                       get_stb,
  input  logic [C_DATAWIDTH-1:0]     get_data
);

  typedef enum logic [1:0] {W_IDLE, W_STB, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_STB, R_RESP} r_state_t;

  w_state_t               w_state, w_next;
  r_state_t               r_state, r_next;
  logic                   aw_done, w_done;
  logic                   aw_fire, w_fire, ar_fire;
  logic                   strb_ok;
  logic [C_ADDRWIDTH-1:0] aw_addr_q;
  logic [C_DATAWIDTH-1:0] w_data_q;

  // Handshake outputs are gated by rst so nothing is offered while reset is held.
  assign s_axi_awready = !rst && (w_state == W_IDLE) && !aw_done;
  assign s_axi_wready  = !rst && (w_state == W_IDLE) && !w_done;
  assign s_axi_bvalid  = !rst && (w_state == W_RESP);
  assign s_axi_arready = !rst && (r_state == R_IDLE);
  assign s_axi_rvalid  = !rst && (r_state == R_RESP);
  assign s_axi_rresp   = 2'b00;
  assign get_stb       = !rst && (r_state == R_STB);

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid  && s_axi_wready;
  assign ar_fire = s_axi_arvalid && s_axi_arready;

  always_comb begin
    w_next  = w_state;
    set_stb = 1'b0;
    case (w_state)
      W_IDLE: if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_STB;
      W_STB: begin
        w_next  = W_RESP;
        set_stb = !rst && strb_ok;
      end
      W_RESP: if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      set_addr    <= '0;
      set_data    <= '0;
      s_axi_bresp <= 2'b00;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE) begin
        if (aw_fire) begin
          aw_done   <= 1'b1;
          aw_addr_q <= s_axi_awaddr;
        end
        if (w_fire) begin
          w_done   <= 1'b1;
          w_data_q <= s_axi_wdata;
        end
        // Bypass the holding registers when the last half arrives this cycle.
        if (w_next == W_STB) begin
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          set_addr <= aw_fire ? s_axi_awaddr : aw_addr_q;
          set_data <= w_fire  ? s_axi_wdata  : w_data_q;
        end
      end
      if (w_state == W_STB) s_axi_bresp <= strb_ok ? 2'b00 : 2'b10;
    end
  end

`ifdef SETTINGS_BRIDGE_STRB_CHECK_EN
  logic [C_DATAWIDTH/8-1:0] w_strb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_strb_q <= '0;
      strb_ok  <= 1'b0;
    end else if (w_state == W_IDLE) begin
      if (w_fire) w_strb_q <= s_axi_wstrb;
      if (w_next == W_STB) strb_ok <= &(w_fire ? s_axi_wstrb : w_strb_q);
    end
  end
`else
  logic unused_wstrb;
  assign strb_ok      = 1'b1;
  assign unused_wstrb = ^s_axi_wstrb;
`endif

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_STB;
      R_STB:   r_next = R_RESP;
      R_RESP:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      get_addr    <= '0;
      s_axi_rdata <= '0;
    end else begin
      r_state <= r_next;
      if (ar_fire) get_addr <= s_axi_araddr;
      if (r_state == R_STB) s_axi_rdata <= get_data;
    end
  end

endmodule

// File: tb/tb_axi_lite_settings_bridge.sv
// Directed bench for axi_lite_settings_bridge: a register-bank model plus transaction
// queues predict every strobe and response; literal checks pin the headline scenarios.
module tb_axi_lite_settings_bridge;

`ifdef SETTINGS_BRIDGE_STRB_CHECK_EN
  localparam bit STRB_CHK = 1'b1;
`else
  localparam bit STRB_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata, set_data, set_addr, get_addr, get_data;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, set_stb, get_stb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_settings_bridge #(.C_DATAWIDTH(32), .C_ADDRWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .set_data(set_data), .set_addr(set_addr), .set_stb(set_stb),
    .get_addr(get_addr), .get_stb(get_stb), .get_data(get_data)
  );

  // Register bank behind the settings port: 16 words, word-addressed by bits [5:2].
  logic [31:0] bank [0:15];
  logic        init_bank, poke_en;
  logic [3:0]  poke_idx;
  logic [31:0] poke_val;
  assign get_data = bank[get_addr[5:2]];

  always @(posedge clk) begin
    if (init_bank) begin
      for (int i = 0; i < 16; i++) bank[i] <= 32'h5A5A0000 + 32'(i * 4);
    end else if (set_stb) begin
      bank[set_addr[5:2]] <= set_data;
    end else if (poke_en) begin
      bank[poke_idx] <= poke_val;
    end
  end

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  logic [31:0] mdl_mem [0:15];
  wr_t         exp_set_q[$];
  logic [1:0]  exp_b_q[$];
  logic [31:0] exp_r_q[$];
  logic [31:0] exp_ra_q[$];
  int checks = 0, errors = 0, n_set_exp = 0, n_set_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit take;
    take = !STRB_CHK || (s == 4'hF);
    if (take) begin
      exp_set_q.push_back({a, d});
      mdl_mem[a[5:2]] = d;
      n_set_exp++;
    end
    exp_b_q.push_back(take ? 2'b00 : 2'b10);
  endtask

  task automatic model_read(input logic [31:0] a);
    exp_ra_q.push_back(a);
    exp_r_q.push_back(mdl_mem[a[5:2]]);
  endtask

  // Timing model: strobe one cycle after both halves are accepted, response one cycle later.
  int   cyc = 0;
  int   exp_stb_cyc = -10, exp_bv_cyc = -10, exp_gs_cyc = -10, exp_rv_cyc = -10;
  bit   aw_seen, w_seen;
  logic prev_set, prev_get, prev_bv, prev_rv;
  wr_t  cmp_e;

  always @(negedge clk) begin
    if (rst) begin
      aw_seen = 0; w_seen = 0;
      exp_stb_cyc = -10; exp_bv_cyc = -10; exp_gs_cyc = -10; exp_rv_cyc = -10;
      prev_set = 0; prev_get = 0; prev_bv = 0; prev_rv = 0;
    end else begin
      if (set_stb) begin
        n_set_seen++;
        check("set_stb_latency", cyc, exp_stb_cyc);
        check("set_stb_single", prev_set, 0);
        if (exp_set_q.size() == 0) check("set_stb_unexpected", set_stb, 0);
        else begin
          cmp_e = exp_set_q.pop_front();
          check("set_addr", set_addr, cmp_e.a);
          check("set_data", set_data, cmp_e.d);
        end
      end
      if (bvalid && !prev_bv) check("bvalid_latency", cyc, exp_bv_cyc);
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) check("bvalid_unexpected", bvalid, 0);
        else check("bresp", bresp, exp_b_q.pop_front());
      end
      if (get_stb) begin
        check("get_stb_latency", cyc, exp_gs_cyc);
        check("get_stb_single", prev_get, 0);
        if (exp_ra_q.size() == 0) check("get_stb_unexpected", get_stb, 0);
        else check("get_addr", get_addr, exp_ra_q.pop_front());
      end
      if (rvalid && !prev_rv) check("rvalid_latency", cyc, exp_rv_cyc);
      if (rvalid && rready) begin
        check("rresp", rresp, 0);
        if (exp_r_q.size() == 0) check("rvalid_unexpected", rvalid, 0);
        else check("rdata", rdata, exp_r_q.pop_front());
      end
      if (awvalid && awready) aw_seen = 1;
      if (wvalid && wready) w_seen = 1;
      if (aw_seen && w_seen) begin
        exp_stb_cyc = cyc + 1; exp_bv_cyc = cyc + 2;
        aw_seen = 0; w_seen = 0;
      end
      if (arvalid && arready) begin
        exp_gs_cyc = cyc + 1; exp_rv_cyc = cyc + 2;
      end
      prev_set = set_stb; prev_get = get_stb; prev_bv = bvalid; prev_rv = rvalid;
    end
    cyc++;
  end

  task automatic send_aw(input logic [31:0] a);
    bit done = 0;
    awaddr = a; awvalid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (awready) begin
        @(posedge clk); #1 awvalid = 0; done = 1;
      end
    end
    if (!done) begin check("aw_timeout", awready, 1); awvalid = 0; end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    wdata = d; wstrb = s; wvalid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (wready) begin
        @(posedge clk); #1 wvalid = 0; done = 1;
      end
    end
    if (!done) begin check("w_timeout", wready, 1); wvalid = 0; end
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit done = 0;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk); #1 arvalid = 0; done = 1;
      end
    end
    if (!done) begin check("ar_timeout", arready, 1); arvalid = 0; end
  endtask

  task automatic wait_b();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bvalid && bready) begin @(posedge clk); #1 done = 1; end
    end
    if (!done) check("b_timeout", bvalid, 1);
  endtask

  task automatic wait_r();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rvalid && rready) begin @(posedge clk); #1 done = 1; end
    end
    if (!done) check("r_timeout", rvalid, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    model_write(a, d, s);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b();
  endtask

  task automatic rd(input logic [31:0] a);
    model_read(a);
    send_ar(a);
    wait_r();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; init_bank = 1; poke_en = 0; poke_idx = '0; poke_val = '0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
    araddr = '0; arvalid = 0; rready = 1;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 32'h5A5A0000 + 32'(i * 4);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readys", {awready, wready, arready}, 3'b000);
    check("rst_valids_stbs", {bvalid, rvalid, set_stb, get_stb}, 4'b0000);
    check("rst_resps", {bresp, rresp}, 4'b0000);
    check("rst_set_regs", {set_addr, set_data}, 64'h0);
    check("rst_get_regs", {get_addr, rdata}, 64'h0);
    @(posedge clk); #1 rst = 0; init_bank = 0;
    @(negedge clk);
    check("readys_after_rst", {awready, wready, arready}, 3'b111);

    // AW and W together
    @(posedge clk); #1;
    model_write(32'h04, 32'h1F, 4'hF);
    awaddr = 32'h04; awvalid = 1; wdata = 32'h1F; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    check("t1_aw_w_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("t1_set_stb", set_stb, 1);
    check("t1_set_addr", set_addr, 32'h04);
    check("t1_set_data", set_data, 32'h1F);
    @(negedge clk);
    check("t1_bvalid", bvalid, 1);
    check("t1_bresp", bresp, 2'b00);
    @(posedge clk); #1;

    // W three cycles ahead of AW
    model_write(32'h08, 32'hA5, 4'hF);
    wdata = 32'hA5; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    check("t2_wready_first", wready, 1);
    @(posedge clk); #1 wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_wready_held_low", wready, 0);
      check("t2_no_early_stb", set_stb, 0);
    end
    @(posedge clk); #1 awaddr = 32'h08; awvalid = 1;
    @(negedge clk);
    check("t2_awready", awready, 1);
    @(posedge clk); #1 awvalid = 0;
    @(negedge clk);
    check("t2_set_stb", set_stb, 1);
    check("t2_set_data", set_data, 32'hA5);
    wait_b();

    // Read with rready held low for 5 cycles; bank changes underneath
    poke_idx = 4'd0; poke_val = 32'hACE0BA53; poke_en = 1; mdl_mem[0] = 32'hACE0BA53;
    @(posedge clk); #1 poke_en = 0;
    rready = 0;
    model_read(32'h00);
    araddr = 32'h00; arvalid = 1;
    @(negedge clk);
    check("t3_arready", arready, 1);
    @(posedge clk); #1 arvalid = 0;
    @(negedge clk);
    check("t3_get_stb", get_stb, 1);
    check("t3_get_data", get_data, 32'hACE0BA53);
    @(posedge clk); #1 poke_val = 32'h0; poke_en = 1; mdl_mem[0] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_rvalid_held", rvalid, 1);
      check("t3_rdata_stable", rdata, 32'hACE0BA53);
      check("t3_arready_low", arready, 0);
      @(posedge clk); #1 poke_en = 0;
    end
    rready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_after_handshake", {rvalid, arready}, 2'b01);

    // Concurrent write and read
    @(posedge clk); #1;
    model_write(32'h0C, 32'h12345678, 4'hF);
    model_read(32'h14);
    awaddr = 32'h0C; awvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h14; arvalid = 1;
    @(negedge clk);
    check("t4_all_ready", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1 awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    check("t4_both_stb", {set_stb, get_stb}, 2'b11);
    @(negedge clk);
    check("t4_both_valid", {bvalid, rvalid}, 2'b11);
    check("t4_rdata", rdata, 32'h5A5A0014);
    @(posedge clk); #1;

    // Reset in the strobe cycle drops the write
    awaddr = 32'h10; awvalid = 1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    check("t5_accept", {awready, wready}, 2'b11);
    @(posedge clk); #1 awvalid = 0; wvalid = 0; rst = 1;
    @(negedge clk);
    check("t5_no_stb_in_rst", set_stb, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("t5_set_regs_cleared", {set_addr, set_data}, 64'h0);
    check("t5_awready_back", awready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_bvalid", bvalid, 0);
    end
    @(posedge clk); #1;
    wr(32'h18, 32'hBEEF, 4'hF);

    // Partial strobes
    wr(32'h1C, 32'hDEAD, 4'h3);
    rd(32'h1C);

    // A second write is held off while the first response is pending
    bready = 0;
    model_write(32'h20, 32'h1, 4'hF);
    fork
      send_aw(32'h20);
      send_w(32'h1, 4'hF);
    join
    model_write(32'h24, 32'h2, 4'hF);
    fork
      send_aw(32'h24);
      send_w(32'h2, 4'hF);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("t6_blocked_while_pending", {awready, wready}, 2'b00);
        end
        @(posedge clk); #1 bready = 1;
      end
    join
    wait_b();

    // Read back through the bank
    rd(32'h0C);
    rd(32'h04);
    rd(32'h18);
    rd(32'h24);

    repeat (3) @(negedge clk);
    check("left_set_exp", exp_set_q.size(), 0);
    check("left_b_exp", exp_b_q.size(), 0);
    check("left_r_exp", exp_r_q.size(), 0);
    check("set_stb_count", n_set_seen, n_set_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
